// File: rtl/regfile_wb_sink_pkg.sv
// Shared types and constants for the writeback-sink register file and its scoreboard.
package regfile_wb_sink_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int CNT_W_DEF  = 3;
    localparam int NUM_REGS   = 2 ** ADDR_W_DEF;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;
    typedef logic [CNT_W_DEF-1:0]  sb_cnt_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_wb_sink_scoreboard.sv
// In-flight write scoreboard: one saturating counter per register, a sticky
// over/underflow flag, and the per-source pending indications used for stalls.
module reg_scoreboard
    import regfile_wb_sink_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W_DEF,
    parameter int CNT_WIDTH  = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc_i,
    input  logic [ADDR_WIDTH-1:0] inc_add_i,
    input  logic                  dec_i,
    input  logic [ADDR_WIDTH-1:0] dec_add_i,
    input  logic [ADDR_WIDTH-1:0] rs1_add_i,
    input  logic [ADDR_WIDTH-1:0] rs2_add_i,
    input  logic                  rs1_use_i,
    input  logic                  rs2_use_i,
    output logic                  pend1_o,
    output logic                  pend2_o,
    output logic                  err_o
);

    localparam int                   N_REGS  = 2 ** ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADD = ADDR_WIDTH'(REG_ZERO);

    logic [CNT_WIDTH-1:0] cnt_q [N_REGS];
    logic [CNT_WIDTH-1:0] cnt_d [N_REGS];
    logic                 err_q, err_d;
    logic [N_REGS-1:0]    inc_vec, dec_vec;

    assign inc_vec = N_REGS'(inc_i) << inc_add_i;
    assign dec_vec = N_REGS'(dec_i) << dec_add_i;

    // Simultaneous issue and retire on one register cancel; x0 never counts.
    always_comb begin
        err_d = err_q;
        for (int i = 0; i < N_REGS; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        for (int i = 1; i < N_REGS; i++) begin
            if (inc_vec[i] && !dec_vec[i]) begin
                if (cnt_q[i] == CNT_MAX) err_d = 1'b1;
                else                     cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else if (dec_vec[i] && !inc_vec[i]) begin
                if (cnt_q[i] == '0) err_d = 1'b1;
                else                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REGS; i++) begin
                cnt_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // A last outstanding write retiring this cycle is covered by the read bypass.
    assign pend1_o = rs1_use_i && (rs1_add_i != ZERO_ADD) && (cnt_q[rs1_add_i] != '0)
                     && !(dec_vec[rs1_add_i] && (cnt_q[rs1_add_i] == CNT_ONE));
    assign pend2_o = rs2_use_i && (rs2_add_i != ZERO_ADD) && (cnt_q[rs2_add_i] != '0)
                     && !(dec_vec[rs2_add_i] && (cnt_q[rs2_add_i] == CNT_ONE));

    assign err_o = err_q;

endmodule

// File: rtl/regfile_wb_sink.sv
// Integer register file fed by the WB write port, serving two bypassed read
// ports to ID together with a scoreboard-driven source-hazard stall.
module regfile_wb_sink
    import regfile_wb_sink_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W_DEF,
    parameter int ADDR_WIDTH = ADDR_W_DEF,
    parameter int CNT_WIDTH  = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] WB_rd_add_i,
    input  logic [DATA_WIDTH-1:0] WB_data_write_reg_i,
    input  logic                  WB_regwrite_i,
    input  logic [ADDR_WIDTH-1:0] ID_rs1_add_i,
    input  logic [ADDR_WIDTH-1:0] ID_rs2_add_i,
    input  logic                  ID_rs1_use_i,
    input  logic                  ID_rs2_use_i,
    input  logic                  ID_issue_i,
    input  logic [ADDR_WIDTH-1:0] ID_rd_add_i,
    input  logic                  ID_regwrite_i,
    output logic [DATA_WIDTH-1:0] ID_rs1_data_o,
    output logic [DATA_WIDTH-1:0] ID_rs2_data_o,
    output logic                  ID_stall_o,
    output logic                  err_o
);

    localparam int                    N_REGS   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADD = ADDR_WIDTH'(REG_ZERO);

    logic [DATA_WIDTH-1:0] regs_q [N_REGS];
    logic                  wb_wr_en;
    logic                  sb_inc;
    logic                  pend1, pend2;

    // Write-first read: an in-flight WB to the same nonzero register wins.
    function automatic logic [DATA_WIDTH-1:0] read_port(
        input logic [ADDR_WIDTH-1:0] add,
        input logic                  wr_en,
        input logic [ADDR_WIDTH-1:0] wr_add,
        input logic [DATA_WIDTH-1:0] wr_data,
        input logic [DATA_WIDTH-1:0] stored
    );
        if (add == ZERO_ADD)              return '0;
        else if (wr_en && wr_add == add)  return wr_data;
        else                              return stored;
    endfunction

    assign wb_wr_en = WB_regwrite_i && (WB_rd_add_i != ZERO_ADD);
    assign sb_inc   = ID_issue_i && ID_regwrite_i && (ID_rd_add_i != ZERO_ADD) && !ID_stall_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_wr_en) begin
            regs_q[WB_rd_add_i] <= WB_data_write_reg_i;
        end
    end

    assign ID_rs1_data_o = read_port(ID_rs1_add_i, wb_wr_en, WB_rd_add_i,
                                     WB_data_write_reg_i, regs_q[ID_rs1_add_i]);
    assign ID_rs2_data_o = read_port(ID_rs2_add_i, wb_wr_en, WB_rd_add_i,
                                     WB_data_write_reg_i, regs_q[ID_rs2_add_i]);

    reg_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (sb_inc),
        .inc_add_i  (ID_rd_add_i),
        .dec_i      (wb_wr_en),
        .dec_add_i  (WB_rd_add_i),
        .rs1_add_i  (ID_rs1_add_i),
        .rs2_add_i  (ID_rs2_add_i),
        .rs1_use_i  (ID_rs1_use_i),
        .rs2_use_i  (ID_rs2_use_i),
        .pend1_o    (pend1),
        .pend2_o    (pend2),
        .err_o      (err_o)
    );

    assign ID_stall_o = pend1 | pend2;

endmodule
